// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// | product_accumulator_if : input-term and result handshake bundle         |
// | Revision 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

interface product_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  term_cnt;
  logic              ovf;

  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, acc_out, term_cnt, ovf
  );

  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, acc_out, term_cnt, ovf
  );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// | product_accumulator : sums groups of unsigned products into a wide      |
// | accumulator; `define ACC_SAT_EN clamps on overflow instead of wrapping. |
// | Revision 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  wire                    clk,
  input  wire                    rst_n,
  product_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   acc_out_q;
  logic [CNT_W-1:0]   term_cnt_q;
  logic               ovf_out_q;

  logic               in_ready_w;
  logic               accept_w;
  logic [ACC_W:0]     prod_ext_w;
  logic [ACC_W-1:0]   acc_base_w;
  logic [CNT_W-1:0]   cnt_base_w;
  logic               ovf_base_w;
  logic [ACC_W:0]     sum_w;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;

  assign in_ready_w = ~out_valid_q | bus.out_ready;
  assign accept_w   = bus.in_valid & in_ready_w;

  // In IDLE the group starts fresh, so the running terms are forced to zero.
  always_comb begin
    prod_ext_w               = '0;
    prod_ext_w[PROD_W-1:0]   = bus.product;
    acc_base_w               = (state_q == IDLE) ? '0 : acc_q;
    cnt_base_w               = (state_q == IDLE) ? '0 : cnt_q;
    ovf_base_w               = (state_q == IDLE) ? 1'b0 : ovf_q;
    sum_w                    = {1'b0, acc_base_w} + prod_ext_w;
    ovf_d                    = ovf_base_w | sum_w[ACC_W];
    cnt_d                    = (cnt_base_w == {CNT_W{1'b1}}) ? cnt_base_w
                                                             : cnt_base_w + 1'b1;
`ifdef ACC_SAT_EN
    acc_d                    = ovf_d ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    acc_d                    = sum_w[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      term_cnt_q  <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept_w) begin
        if (bus.in_last) begin
          out_valid_q <= 1'b1;
          acc_out_q   <= acc_d;
          term_cnt_q  <= cnt_d;
          ovf_out_q   <= ovf_d;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          state_q     <= IDLE;
        end else begin
          acc_q       <= acc_d;
          cnt_q       <= cnt_d;
          ovf_q       <= ovf_d;
          state_q     <= ACCUM;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.term_cnt  = term_cnt_q;
  assign bus.ovf       = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// | tb_product_accumulator : directed self-checking bench for the            |
// | product accumulator (40-bit and 33-bit accumulator instances).           |
// | Revision 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_product_accumulator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) bus_a ();
  product_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) bus_b ();

  product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [39:0] acc,
                       input logic [7:0] cnt, input logic o);
    chk({tag, ".valid"}, 64'(bus_a.out_valid), 64'(v));
    chk({tag, ".acc"},   64'(bus_a.acc_out),   64'(acc));
    chk({tag, ".cnt"},   64'(bus_a.term_cnt),  64'(cnt));
    chk({tag, ".ovf"},   64'(bus_a.ovf),       64'(o));
  endtask

  task automatic drive_a(input logic v, input logic [31:0] p, input logic last);
    bus_a.in_valid = v;
    bus_a.product  = p;
    bus_a.in_last  = last;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] p, input logic last);
    bus_b.in_valid = v;
    bus_b.product  = p;
    bus_b.in_last  = last;
  endtask

  logic [32:0] exp_b_acc;

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    drive_a(1'b1, 32'd123, 1'b1);
    drive_b(1'b1, 32'd55, 1'b1);

    // Reset held with traffic present
    tick();
    tick();
    chk_a("reset", 1'b0, 40'd0, 8'd0, 1'b0);
    chk("reset.b_valid", 64'(bus_b.out_valid), 64'd0);
    chk("reset.in_ready", 64'(bus_a.in_ready), 64'd1);
    rst_n = 1'b1;
    drive_b(1'b0, 32'd0, 1'b0);

    // Group of three
    drive_a(1'b1, 32'd6, 1'b0);
    tick();
    drive_a(1'b1, 32'd20, 1'b0);
    tick();
    chk("grp3.mid_valid", 64'(bus_a.out_valid), 64'd0);
    drive_a(1'b1, 32'hFFFE0001, 1'b1);
    tick();
    chk_a("grp3", 1'b1, 40'hFFFE001B, 8'd3, 1'b0);

    // Backpressure: a pending last term must not be taken while stalled
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 32'd99, 1'b1);
    #1;
    chk("bp.in_ready", 64'(bus_a.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a("bp.hold", 1'b1, 40'hFFFE001B, 8'd3, 1'b0);
    end
    bus_a.out_ready = 1'b1;
    drive_a(1'b0, 32'd0, 1'b0);
    tick();
    chk("bp.drop", 64'(bus_a.out_valid), 64'd0);

    // Back-to-back single-term groups
    drive_a(1'b1, 32'd7, 1'b1);
    tick();
    chk_a("b2b.first", 1'b1, 40'd7, 8'd1, 1'b0);
    drive_a(1'b1, 32'd9, 1'b1);
    tick();
    chk_a("b2b.second", 1'b1, 40'd9, 8'd1, 1'b0);
    drive_a(1'b0, 32'd0, 1'b0);
    tick();
    chk("b2b.drop", 64'(bus_a.out_valid), 64'd0);

    // Mid-group reset discards partial sum
    drive_a(1'b1, 32'd100, 1'b0);
    tick();
    drive_a(1'b1, 32'd200, 1'b0);
    tick();
    drive_a(1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_a(1'b1, 32'd5, 1'b1);
    tick();
    chk_a("midrst", 1'b1, 40'd5, 8'd1, 1'b0);
    drive_a(1'b0, 32'd0, 1'b0);
    tick();

    // Term counter saturation: 300 terms of 1
    for (int i = 0; i < 299; i++) begin
      drive_a(1'b1, 32'd1, 1'b0);
      tick();
    end
    drive_a(1'b1, 32'd1, 1'b1);
    tick();
    chk_a("cntsat", 1'b1, 40'd300, 8'd255, 1'b0);
    drive_a(1'b0, 32'd0, 1'b0);
    tick();

    // 33-bit accumulator overflow
    drive_b(1'b1, 32'hFFFE0001, 1'b0);
    tick();
    tick();
    drive_b(1'b1, 32'hFFFE0001, 1'b1);
    tick();
`ifdef ACC_SAT_EN
    exp_b_acc = 33'h1FFFFFFFF;
`else
    exp_b_acc = 33'h0FFFA0003;
`endif
    chk("ovf33.valid", 64'(bus_b.out_valid), 64'd1);
    chk("ovf33.acc",   64'(bus_b.acc_out),   64'(exp_b_acc));
    chk("ovf33.cnt",   64'(bus_b.term_cnt),  64'd3);
    chk("ovf33.ovf",   64'(bus_b.ovf),       64'd1);

    // Overflow must not leak into the next group
    drive_b(1'b1, 32'd1, 1'b1);
    tick();
    chk("ovf33.next_acc", 64'(bus_b.acc_out), 64'd1);
    chk("ovf33.next_ovf", 64'(bus_b.ovf),     64'd0);
    drive_b(1'b0, 32'd0, 1'b0);
    tick();
    chk("ovf33.drop", 64'(bus_b.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
